fir_coeff_sequencer: RTL

- Controller that reloads the 128-tap FIR coefficient set from an external coefficient memory holding NSETS sets.
- Streams TAPS words into the coefficient loader over its cfg_vld/cfg_data interface and waits for the loader's done flag.
- Swaps the filter's active bank only on a sample boundary, then clears the loader for the next load.
- Sits between the host/control register block and the coefficient loader.

---
 rtl/fir_coeff_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fir_coeff_sequencer.sv
// Reloads one FIR coefficient set from external memory into the coefficient loader,
// then swaps the filter bank on the next sample boundary once the loader reports done.
module fir_coeff_sequencer #(
  parameter int  TAPS    = 128,
  parameter int  BW      = 16,
  parameter int  NSETS   = 4,
  parameter int  TIMEOUT = 16,
  localparam int SETW    = (NSETS > 1) ? $clog2(NSETS) : 1,
  localparam int AW      = SETW + $clog2(TAPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  input  logic [SETW-1:0] req_set,
  output logic            req_rdy,
  input  logic            abort,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [BW-1:0]   mem_rd_data,
  output logic            cfg_vld,
  output logic [BW-1:0]   cfg_data,
  input  logic            ld_done,
  output logic            ld_clr,
  input  logic            sample_strobe,
  output logic            bank_swap,
  output logic [SETW-1:0] active_set,
  output logic            busy,
  output logic            err_timeout
);

  localparam int IDXW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNTW = $clog2(TIMEOUT + 1);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(TIMEOUT - 1);
  localparam logic [SETW-1:0] LAST_SET = SETW'(NSETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT_DONE,
    S_WAIT_SWAP
  } state_t;

  state_t            state, state_nxt;
  logic [SETW-1:0]   pend_set;
  logic [IDXW-1:0]   idx;
  logic [CNTW-1:0]   cnt;
  logic              armed;
  logic              cfg_vld_q;
  logic              abort_q;
  logic              err_q;
  logic [SETW-1:0]   active_q;
  logic              timeout_fire;
  logic              swap_fire;
  logic              set_in_range;

  assign set_in_range = ({1'b0, req_set} < (SETW + 1)'(NSETS));

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves a latch behind.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req_vld) state_nxt = S_FETCH;
      S_FETCH:     if (idx == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (ld_done)              state_nxt = S_WAIT_SWAP;
        else if (cnt == LAST_CNT) state_nxt = S_IDLE;
      end
      S_WAIT_SWAP: if (armed && sample_strobe) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_comb begin
    req_rdy      = (state == S_IDLE);
    busy         = (state != S_IDLE);
    mem_rd_en    = (state == S_FETCH);
    mem_addr     = mem_rd_en ? (AW'(pend_set) * AW'(TAPS) + AW'(idx)) : '0;
    // cnt holds (cycles spent in WAIT_DONE - 1), so the last allowed cycle is TIMEOUT after DRAIN.
    timeout_fire = (state == S_WAIT_DONE) && !ld_done && (cnt == LAST_CNT) && !abort;
    swap_fire    = (state == S_WAIT_SWAP) && armed && sample_strobe && !abort;
    bank_swap    = swap_fire;
    ld_clr       = swap_fire || timeout_fire || abort_q;
    err_timeout  = err_q || timeout_fire;
    cfg_vld      = cfg_vld_q;
    cfg_data     = cfg_vld_q ? mem_rd_data : '0;
    active_set   = active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_set  <= '0;
      idx       <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      cfg_vld_q <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= '0;
    end else begin
      // An aborted read still returns data next cycle; it is simply never marked valid.
      cfg_vld_q <= mem_rd_en && !abort;
      // The abort clear is delayed one cycle so it never overlaps a valid coefficient.
      abort_q   <= abort && busy;
      armed     <= (state == S_WAIT_SWAP);
      cnt       <= (state == S_WAIT_DONE) ? cnt + CNTW'(1) : '0;
      if (req_vld && req_rdy) begin
        pend_set <= set_in_range ? req_set : LAST_SET;
        idx      <= '0;
        err_q    <= 1'b0;
      end else if (mem_rd_en) begin
        idx <= idx + IDXW'(1);
      end
      if (timeout_fire) err_q    <= 1'b1;
      if (swap_fire)    active_q <= pend_set;
    end
  end

endmodule
